// File: rtl/seven_seg_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment driver with frame-synchronous
// data update, per-slot anode dead time and whole-display blink.
module seven_seg_scan_driver #(
  parameter int SCAN_DIV  = 25000,
  parameter int BLINK_DIV = 2500000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] digit_codes,
  input  logic [3:0]  digit_blank,
  input  logic [3:0]  dp,
  input  logic        blink_en,
  output logic [3:0]  anodes,
  output logic [7:0]  cathods,
  output logic        frame_done
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_PRE   = SCAN_W'(SCAN_DIV - 2);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [1:0]         digit_idx_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_phase_r;
  logic [15:0]        shadow_codes_r, active_codes_r;
  logic [3:0]         shadow_blank_r, active_blank_r;
  logic [3:0]         shadow_dp_r, active_dp_r;
  logic               shadow_blink_r, active_blink_r;
  logic [3:0]         anodes_r;
  logic [7:0]         cathods_r;
  logic               frame_done_r;

  logic               scan_last_s;
  logic               frame_end_s;
  logic               frame_pre_s;
  logic [3:0]         cur_code_s;
  logic               cur_dark_s;
  logic [3:0]         anodes_s;
  logic [7:0]         cathods_s;

  assign scan_last_s = (scan_cnt_r == SCAN_LAST);
  assign frame_end_s = scan_last_s && (digit_idx_r == 2'd0);
  // frame_done is registered one cycle early so it is high exactly on the frame-end cycle
  assign frame_pre_s = (scan_cnt_r == SCAN_PRE) && (digit_idx_r == 2'd0);

  // Slot counter and digit index; index steps down 3->0 and wraps naturally
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_r  <= {SCAN_W{1'b0}};
      digit_idx_r <= 2'd3;
    end else if (scan_last_s) begin
      scan_cnt_r  <= {SCAN_W{1'b0}};
      digit_idx_r <= digit_idx_r - 2'd1;
    end else begin
      scan_cnt_r  <= scan_cnt_r + {{(SCAN_W-1){1'b0}}, 1'b1};
    end
  end

  // Free-running blink timebase
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_r   <= {BLINK_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r   <= {BLINK_W{1'b0}};
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + {{(BLINK_W-1){1'b0}}, 1'b1};
    end
  end

  // Shadow capture on load; active copy at frame end, with load bypassing the shadow
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_codes_r <= 16'h0000;
      shadow_blank_r <= 4'b1111;
      shadow_dp_r    <= 4'b0000;
      shadow_blink_r <= 1'b0;
      active_codes_r <= 16'h0000;
      active_blank_r <= 4'b1111;
      active_dp_r    <= 4'b0000;
      active_blink_r <= 1'b0;
    end else begin
      if (load) begin
        shadow_codes_r <= digit_codes;
        shadow_blank_r <= digit_blank;
        shadow_dp_r    <= dp;
        shadow_blink_r <= blink_en;
      end
      if (frame_end_s) begin
        active_codes_r <= load ? digit_codes : shadow_codes_r;
        active_blank_r <= load ? digit_blank : shadow_blank_r;
        active_dp_r    <= load ? dp          : shadow_dp_r;
        active_blink_r <= load ? blink_en    : shadow_blink_r;
      end
    end
  end

  // Pattern for the current slot; slot cycle 0 keeps all anodes off
  always_comb begin
    cur_code_s = 4'h0;
    cathods_s  = 8'hFF;
    anodes_s   = 4'b1111;
    case (digit_idx_r)
      2'd0:    cur_code_s = active_codes_r[3:0];
      2'd1:    cur_code_s = active_codes_r[7:4];
      2'd2:    cur_code_s = active_codes_r[11:8];
      2'd3:    cur_code_s = active_codes_r[15:12];
      default: cur_code_s = 4'h0;
    endcase
    cur_dark_s = active_blank_r[digit_idx_r] || (active_blink_r && blink_phase_r);
    if (cur_dark_s) begin
      cathods_s = 8'hFF;
    end else begin
      cathods_s = {~active_dp_r[digit_idx_r], hex_to_seg(cur_code_s)};
    end
    if (scan_cnt_r == {SCAN_W{1'b0}}) begin
      anodes_s = 4'b1111;
    end else begin
      anodes_s = ~(4'b0001 << digit_idx_r);
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      anodes_r     <= 4'b1111;
      cathods_r    <= 8'hFF;
      frame_done_r <= 1'b0;
    end else begin
      anodes_r     <= anodes_s;
      cathods_r    <= cathods_s;
      frame_done_r <= frame_pre_s;
    end
  end

  assign anodes     = anodes_r;
  assign cathods    = cathods_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver (SCAN_DIV=4, BLINK_DIV=16).
module tb_seven_seg_scan_driver;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digit_codes = 16'h0000;
  logic [3:0]  digit_blank = 4'b0000;
  logic [3:0]  dp = 4'b0000;
  logic        blink_en = 1'b0;
  logic [3:0]  anodes;
  logic [7:0]  cathods;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  seven_seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clock(clock), .reset_n(reset_n), .load(load), .digit_codes(digit_codes),
    .digit_blank(digit_blank), .dp(dp), .blink_en(blink_en),
    .anodes(anodes), .cathods(cathods), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    load = 1'b0;
    cyc++;
  endtask

  // One 4-cycle digit slot: dead cycle then three lit cycles; frame_done on the third
  task automatic check_slot(input string tag, input logic [3:0] an, input logic [7:0] cat,
                            input bit arm);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_an"}, {4'h0, anodes}, (i == 0) ? 8'h0F : {4'h0, an});
      chk({tag, "_cat"}, cathods, cat);
      chk({tag, "_fd"}, {7'h0, frame_done}, (an == 4'b1110 && i == 2) ? 8'h01 : 8'h00);
      if (arm && i == 2) load = 1'b1;
    end
  endtask

  task automatic set_inputs(input logic [15:0] c, input logic [3:0] b, input logic [3:0] d,
                            input logic be);
    digit_codes = c;
    digit_blank = b;
    dp          = d;
    blink_en    = be;
  endtask

  initial begin
    // T1: asynchronous reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_an", {4'h0, anodes}, 8'h0F);
    chk("rst_cat", cathods, 8'hFF);
    chk("rst_fd", {7'h0, frame_done}, 8'h00);
    repeat (2) begin
      @(posedge clock);
      #1;
      chk("rst_hold_fd", {7'h0, frame_done}, 8'h00);
    end
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
    tick();
    chk("rel1_an", {4'h0, anodes}, 8'h0F);
    chk("rel1_cat", cathods, 8'hFF);
    tick();
    chk("rel2_an", {4'h0, anodes}, 8'h07);
    chk("rel2_cat", cathods, 8'hFF);

    // T2: load 1234 in frame 0, shown from frame 1
    set_inputs(16'h1234, 4'b0000, 4'b0000, 1'b0);
    load = 1'b1;
    tick();
    repeat (12) tick();
    chk("f0_fd", {7'h0, frame_done}, 8'h01);
    chk("f0_still_dark", cathods, 8'hFF);
    tick();
    chk("f0_fd_end", {7'h0, frame_done}, 8'h00);
    check_slot("f1_d3", 4'b0111, 8'hF9, 1'b0);
    check_slot("f1_d2", 4'b1011, 8'hA4, 1'b0);
    check_slot("f1_d1", 4'b1101, 8'hB0, 1'b0);
    check_slot("f1_d0", 4'b1110, 8'h99, 1'b0);

    // T3: load ABCD mid-frame does not tear the current frame
    check_slot("f2_d3", 4'b0111, 8'hF9, 1'b0);
    check_slot("f2_d2", 4'b1011, 8'hA4, 1'b0);
    set_inputs(16'hABCD, 4'b0000, 4'b0000, 1'b0);
    load = 1'b1;
    check_slot("f2_d1", 4'b1101, 8'hB0, 1'b0);
    check_slot("f2_d0", 4'b1110, 8'h99, 1'b0);
    // Frame 3 shows ABCD; T4 inputs loaded on the frame_done cycle bypass to active
    set_inputs(16'h8888, 4'b0101, 4'b1000, 1'b0);
    check_slot("f3_d3", 4'b0111, 8'h88, 1'b0);
    check_slot("f3_d2", 4'b1011, 8'h83, 1'b0);
    check_slot("f3_d1", 4'b1101, 8'hC6, 1'b0);
    check_slot("f3_d0", 4'b1110, 8'hA1, 1'b1);

    // T4: blank bits 0 and 2, dp on digit 3
    check_slot("f4_d3", 4'b0111, 8'h00, 1'b0);
    check_slot("f4_d2", 4'b1011, 8'hFF, 1'b0);
    check_slot("f4_d1", 4'b1101, 8'h80, 1'b0);
    set_inputs(16'h1234, 4'b0000, 4'b0000, 1'b1);
    load = 1'b1;
    check_slot("f4_d0", 4'b1110, 8'hFF, 1'b0);

    // T5: blink enabled; frame 5 in dark phase, frame 6 lit, frame 7 dark
    check_slot("f5_d3", 4'b0111, 8'hFF, 1'b0);
    check_slot("f5_d2", 4'b1011, 8'hFF, 1'b0);
    check_slot("f5_d1", 4'b1101, 8'hFF, 1'b0);
    check_slot("f5_d0", 4'b1110, 8'hFF, 1'b0);
    check_slot("f6_d3", 4'b0111, 8'hF9, 1'b0);
    check_slot("f6_d2", 4'b1011, 8'hA4, 1'b0);
    check_slot("f6_d1", 4'b1101, 8'hB0, 1'b0);
    check_slot("f6_d0", 4'b1110, 8'h99, 1'b0);
    check_slot("f7_d3", 4'b0111, 8'hFF, 1'b0);

    // Reset mid-slot: dark immediately, restart at digit3 with blanked data
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_an", {4'h0, anodes}, 8'h0F);
    chk("mid_rst_cat", cathods, 8'hFF);
    chk("mid_rst_fd", {7'h0, frame_done}, 8'h00);
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("mid_rst_hold_fd", {7'h0, frame_done}, 8'h00);
      chk("mid_rst_hold_an", {4'h0, anodes}, 8'h0F);
    end
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
    tick();
    chk("rel_b1_an", {4'h0, anodes}, 8'h0F);
    chk("rel_b1_cat", cathods, 8'hFF);
    tick();
    chk("rel_b2_an", {4'h0, anodes}, 8'h07);
    chk("rel_b2_cat", cathods, 8'hFF);
    repeat (13) tick();
    chk("rel_b_fd", {7'h0, frame_done}, 8'h01);
    tick();
    chk("rel_b_fd_end", {7'h0, frame_done}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
